signal_period_analyzer: RTL

- Receive-side counterpart of the DDS waveform generator: consumes the 8-bit unsigned sample stream the generator emits on signal_8bit and recovers the waveform's period and peak levels.
- Detects rising midscale crossings with hysteresis and counts the valid samples between consecutive crossings.
- Reports period, max and min once per cycle of the waveform.
- Sits on the loopback / measurement path, e.g. a generator-to-analyzer self-test or an external ADC input.

---
 rtl/signal_period_analyzer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/signal_period_analyzer.sv
// Recovers period and peak levels of an 8-bit sample stream from
// rising midscale crossings with a hysteresis band.
module signal_period_analyzer #(
  parameter int unsigned MAX_PERIOD = 65536,
  parameter logic [7:0]  MIDSCALE   = 8'd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [7:0]  sample,
  input  logic [7:0]  hysteresis,
  output logic [31:0] period,
  output logic [7:0]  peak_max,
  output logic [7:0]  peak_min,
  output logic        result_valid,
  output logic        timeout,
  output logic        locked
);

  typedef enum logic [1:0] {
    ARM_LOW   = 2'd0,
    ARM_HIGH  = 2'd1,
    MEAS_LOW  = 2'd2,
    MEAS_HIGH = 2'd3
  } state_e;

  localparam logic [31:0] CNT_LAST = 32'(MAX_PERIOD - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  run_max_q, run_max_d;
  logic [7:0]  run_min_q, run_min_d;
  logic [31:0] period_q, period_d;
  logic [7:0]  pmax_q, pmax_d;
  logic [7:0]  pmin_q, pmin_d;
  logic        rv_q, rv_d;
  logic        to_q, to_d;
  logic        locked_q, locked_d;

  logic [7:0] h;
  logic [8:0] hi_sum;
  logic [7:0] hi_th;
  logic [7:0] lo_th;
  logic       is_low;
  logic       is_high;
  logic [7:0] nmax;
  logic [7:0] nmin;

  assign h      = hysteresis[7] ? 8'd127 : hysteresis;
  assign hi_sum = {1'b0, MIDSCALE} + {1'b0, h};
  assign hi_th  = hi_sum[8] ? 8'd255 : hi_sum[7:0];
  assign lo_th  = (MIDSCALE >= h) ? (MIDSCALE - h) : 8'd0;

  assign is_low  = sample < lo_th;
  assign is_high = sample >= hi_th;
  assign nmax    = (sample > run_max_q) ? sample : run_max_q;
  assign nmin    = (sample < run_min_q) ? sample : run_min_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    period_d  = period_q;
    pmax_d    = pmax_q;
    pmin_d    = pmin_q;
    rv_d      = 1'b0;
    to_d      = 1'b0;
    locked_d  = locked_q;
    if (sample_valid) begin
      unique case (state_q)
        ARM_LOW: begin
          if (is_low) state_d = ARM_HIGH;
        end
        ARM_HIGH: begin
          if (is_high) begin
            cnt_d     = '0;
            run_max_d = sample;
            run_min_d = sample;
            state_d   = MEAS_LOW;
          end
        end
        MEAS_LOW, MEAS_HIGH: begin
          if (state_q == MEAS_HIGH && is_high) begin
            period_d  = cnt_q + 32'd1;
            pmax_d    = run_max_q;
            pmin_d    = run_min_q;
            rv_d      = 1'b1;
            locked_d  = 1'b1;
            cnt_d     = '0;
            run_max_d = sample;
            run_min_d = sample;
            state_d   = MEAS_LOW;
          end else if (cnt_q == CNT_LAST) begin
            to_d     = 1'b1;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = ARM_LOW;
          end else begin
            cnt_d     = cnt_q + 32'd1;
            run_max_d = nmax;
            run_min_d = nmin;
            if (state_q == MEAS_LOW && is_low) state_d = MEAS_HIGH;
          end
        end
        default: state_d = ARM_LOW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARM_LOW;
      cnt_q     <= '0;
      run_max_q <= 8'd0;
      run_min_q <= 8'd255;
      period_q  <= '0;
      pmax_q    <= '0;
      pmin_q    <= '0;
      rv_q      <= 1'b0;
      to_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      period_q  <= period_d;
      pmax_q    <= pmax_d;
      pmin_q    <= pmin_d;
      rv_q      <= rv_d;
      to_q      <= to_d;
      locked_q  <= locked_d;
    end
  end

  assign period       = period_q;
  assign peak_max     = pmax_q;
  assign peak_min     = pmin_q;
  assign result_valid = rv_q;
  assign timeout      = to_q;
  assign locked       = locked_q;

endmodule
